music_fx_engine: RTL

//  Parametrised tone-effects stage; sits between the note generator and the pin driver.

---
 rtl/music_fx_pkg.sv | 19 +
 rtl/music_fx_engine_period_meter.sv | 59 +++++
 rtl/music_fx_engine.sv | 96 +++++++++
 3 files changed

// File: rtl/music_fx_pkg.sv
// Shared types and helpers for the music effects engine.
package music_fx_pkg;

    localparam int unsigned OCT_SEL_W   = 2;
    localparam int unsigned TREM_RATE_W = 4;

    typedef enum logic [1:0] {
        MODE_PASS,
        MODE_DN,
        MODE_UP
    } mode_e;

    // Bit index of the LFO counter used as the tremolo gate; higher rate picks a lower (faster) bit.
    function automatic int unsigned lfo_tap(input logic [TREM_RATE_W-1:0] rate,
                                            input int unsigned             lfo_w);
        return lfo_w - 1 - 32'(rate);
    endfunction

endpackage

// File: rtl/music_fx_engine_period_meter.sv
// Half-period meter and octave-up pulse generator driven by synchronised tone edges.
module period_meter #(
    parameter int unsigned PER_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic ts_edge,
    output logic up,
    output logic period_vld
);

    localparam logic [PER_W-1:0] HP_MAX = '1;
    localparam logic [PER_W-1:0] HP_ONE = PER_W'(1);

    logic [PER_W-1:0] hp_cnt;
    logic [PER_W-1:0] hp_meas;
    logic [PER_W-1:0] q_cnt;
    logic [1:0]       edges;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hp_cnt     <= '0;
            hp_meas    <= '0;
            q_cnt      <= '0;
            edges      <= '0;
            up         <= 1'b0;
            period_vld <= 1'b0;
        end else if (ena) begin
            if (ts_edge) begin
                // An edge takes priority over saturation; the pulse uses the previous measurement.
                hp_cnt  <= '0;
                hp_meas <= (hp_cnt == HP_MAX) ? HP_MAX : hp_cnt + HP_ONE;
                if (edges != 2'd2) edges <= edges + 2'd1;
                if (edges != 2'd0) period_vld <= 1'b1;
                if (period_vld) begin
                    up    <= 1'b1;
                    q_cnt <= hp_meas >> 1;
                end
            end else begin
                if (hp_cnt != HP_MAX) hp_cnt <= hp_cnt + HP_ONE;
                if (hp_cnt >= HP_MAX - HP_ONE) begin
                    period_vld <= 1'b0;
                    edges      <= '0;
                    up         <= 1'b0;
                    q_cnt      <= '0;
                end else if (up) begin
                    if (q_cnt <= HP_ONE) begin
                        up    <= 1'b0;
                        q_cnt <= '0;
                    end else begin
                        q_cnt <= q_cnt - HP_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/music_fx_engine.sv
// Tone effects stage: octave-down divider, octave-up doubler and LFO tremolo on one square-wave tone.
module music_fx_engine
    import music_fx_pkg::*;
#(
    parameter int unsigned PER_W = 16,
    parameter int unsigned OCT_N = 3,
    parameter int unsigned LFO_W = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   tone_i,
    input  logic [OCT_SEL_W-1:0]   oct_dn_sel,
    input  logic                   oct_up_ena,
    input  logic                   trem_ena,
    input  logic [TREM_RATE_W-1:0] trem_rate,
    output logic                   out_o,
    output logic                   trem_o,
    output logic                   period_vld
);

    logic             tone_s1;
    logic             ts;
    logic             ts_d;
    logic [OCT_N-1:0] dn_cnt;
    logic [LFO_W-1:0] lfo_cnt;
    logic [LFO_W-1:0] lfo_sh;
    logic             ts_edge;
    logic             ts_rise;
    logic             up;
    logic             dn_tap;
    logic             lfo;
    logic             mux;
    mode_e            mode;
    int unsigned      sel_k;

    assign ts_edge = ts ^ ts_d;
    assign ts_rise = ts & ~ts_d;

    period_meter #(
        .PER_W(PER_W)
    ) u_period_meter (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ts_edge    (ts_edge),
        .up         (up),
        .period_vld (period_vld)
    );

    always_comb begin
        mode = MODE_PASS;
        if (oct_dn_sel != '0) mode = MODE_DN;
        else if (oct_up_ena)  mode = MODE_UP;

        // Selections beyond the divider depth fall back to the deepest stage.
        sel_k  = (32'(oct_dn_sel) > OCT_N) ? OCT_N : 32'(oct_dn_sel);
        dn_tap = dn_cnt[OCT_N-1];
        for (int unsigned i = 0; i < OCT_N; i++) begin
            if (i + 1 == sel_k) dn_tap = dn_cnt[i];
        end

        lfo_sh = lfo_cnt >> lfo_tap(trem_rate, LFO_W);
        lfo    = lfo_sh[0];

        case (mode)
            MODE_DN: mux = dn_tap;
            MODE_UP: mux = up;
            default: mux = ts;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tone_s1 <= 1'b0;
            ts      <= 1'b0;
            ts_d    <= 1'b0;
            dn_cnt  <= '0;
            lfo_cnt <= '0;
            out_o   <= 1'b0;
            trem_o  <= 1'b0;
        end else if (ena) begin
            tone_s1 <= tone_i;
            ts      <= tone_s1;
            ts_d    <= ts;
            if (ts_rise) dn_cnt <= dn_cnt + 1'b1;
            lfo_cnt <= lfo_cnt + 1'b1;
            out_o   <= mux;
            trem_o  <= trem_ena ? (mux & lfo) : mux;
        end else begin
            out_o  <= 1'b0;
            trem_o <= 1'b0;
        end
    end

endmodule
